// File: rtl/register_bank.sv
// General-purpose register bank: two async read ports, a load port, an indexed
// inc/dec port with programmable step, an auto-incrementing PC and a wrap flag.
module register_bank #(
   parameter int unsigned     WIDTH    = 16,
   parameter int unsigned     DEPTH    = 16,
   parameter int unsigned     PC_INDEX = DEPTH - 1,
   parameter logic [WIDTH-1:0] RESET_PC = '0,
   parameter int unsigned     PC_STEP  = 1,
   parameter bit              ZERO_R0  = 1'b0,
   localparam int unsigned    AW       = $clog2(DEPTH)
) (
   input  logic             CLK,
   input  logic             RESETN,
   input  logic [WIDTH-1:0] DIN,
   input  logic [AW-1:0]    ADDR_A,
   input  logic [AW-1:0]    ADDR_B,
   input  logic             LD,
   input  logic             IDX_EN,
   input  logic             IDX_INC,
   input  logic [3:0]       IDX_STEP,
   input  logic             PC_INC,
   output logic [WIDTH-1:0] DOUT_A,
   output logic [WIDTH-1:0] DOUT_B,
   output logic [WIDTH-1:0] DOUT_PC,
   output logic             WRAP
);

   logic [WIDTH-1:0] regs      [DEPTH];
   logic [WIDTH-1:0] regs_next [DEPTH];
   logic [WIDTH:0]   idx_res;
   logic [WIDTH:0]   step_ext;
   logic             idx_live;
   logic             wrap_next;

   // Extra MSB of the index result holds the carry (add) or borrow (subtract).
   always_comb begin
      step_ext = (WIDTH+1)'(IDX_STEP);
      if (IDX_INC) idx_res = {1'b0, regs[ADDR_B]} + step_ext;
      else         idx_res = {1'b0, regs[ADDR_B]} - step_ext;
   end

   // An IDX op only counts when not overridden by LD and not aimed at a hard zero.
   always_comb begin
      idx_live  = IDX_EN && (IDX_STEP != 4'd0)
                  && !(LD && (ADDR_A == ADDR_B))
                  && !(ZERO_R0 && (ADDR_B == AW'(0)));
      wrap_next = idx_live && idx_res[WIDTH];
   end

   always_comb begin
      for (int r = 0; r < int'(DEPTH); r++) begin
         regs_next[r] = regs[r];
         if (LD && (ADDR_A == AW'(r)))
            regs_next[r] = DIN;
         else if (IDX_EN && (ADDR_B == AW'(r)))
            regs_next[r] = idx_res[WIDTH-1:0];
         else if ((r == int'(PC_INDEX)) && PC_INC)
            regs_next[r] = regs[r] + WIDTH'(PC_STEP);
      end
      if (ZERO_R0) regs_next[0] = '0;
   end

   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         for (int r = 0; r < int'(DEPTH); r++)
            regs[r] <= (r == int'(PC_INDEX)) ? RESET_PC : '0;
         WRAP <= 1'b0;
      end else begin
         for (int r = 0; r < int'(DEPTH); r++)
            regs[r] <= regs_next[r];
         WRAP <= wrap_next;
      end
   end

   always_comb begin
      DOUT_A  = (ZERO_R0 && (ADDR_A == AW'(0))) ? '0 : regs[ADDR_A];
      DOUT_B  = (ZERO_R0 && (ADDR_B == AW'(0))) ? '0 : regs[ADDR_B];
      DOUT_PC = regs[PC_INDEX];
   end

endmodule

// File: tb/tb_register_bank.sv
// Scoreboard bench for register_bank: two instances (ZERO_R0 = 0 / 1) share
// directed stimulus; expected outputs are queued and checked by a monitor.
module tb_register_bank;

   typedef struct {
      int          dut;
      int          sig;
      logic [15:0] val;
      string       name;
      int          tag;
   } exp_t;

   logic        CLK = 1'b0;
   logic        RESETN;
   logic [15:0] DIN;
   logic [3:0]  ADDR_A, ADDR_B, IDX_STEP;
   logic        LD, IDX_EN, IDX_INC, PC_INC;
   logic [15:0] a0, b0, pc0, a1, b1, pc1;
   logic        w0, w1;

   exp_t q[$];
   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;

   register_bank #(.WIDTH(16), .DEPTH(16), .RESET_PC(16'h0100), .ZERO_R0(1'b0)) dut0 (
      .CLK(CLK), .RESETN(RESETN), .DIN(DIN), .ADDR_A(ADDR_A), .ADDR_B(ADDR_B),
      .LD(LD), .IDX_EN(IDX_EN), .IDX_INC(IDX_INC), .IDX_STEP(IDX_STEP), .PC_INC(PC_INC),
      .DOUT_A(a0), .DOUT_B(b0), .DOUT_PC(pc0), .WRAP(w0));

   register_bank #(.WIDTH(16), .DEPTH(16), .RESET_PC(16'h0100), .ZERO_R0(1'b1)) dut1 (
      .CLK(CLK), .RESETN(RESETN), .DIN(DIN), .ADDR_A(ADDR_A), .ADDR_B(ADDR_B),
      .LD(LD), .IDX_EN(IDX_EN), .IDX_INC(IDX_INC), .IDX_STEP(IDX_STEP), .PC_INC(PC_INC),
      .DOUT_A(a1), .DOUT_B(b1), .DOUT_PC(pc1), .WRAP(w1));

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   function automatic logic [15:0] actual(input int d, input int s);
      case (s)
         0:       return (d == 0) ? a0  : a1;
         1:       return (d == 0) ? b0  : b1;
         2:       return (d == 0) ? pc0 : pc1;
         default: return (d == 0) ? 16'(w0) : 16'(w1);
      endcase
   endfunction

   // Monitor: outputs settle mid-cycle, so compare everything due on the falling edge.
   always @(negedge CLK) begin
      while (q.size() > 0 && q[0].tag <= cyc) begin
         exp_t e;
         logic [15:0] act;
         e   = q.pop_front();
         act = actual(e.dut, e.sig);
         n_checks++;
         if (act !== e.val) begin
            n_fail++;
            $display("FAIL %s (dut%0d): got %h expected %h", e.name, e.dut, act, e.val);
         end
      end
   end

   task automatic expect_now(input int d, input int s, input logic [15:0] v, input string nm);
      q.push_back('{dut: d, sig: s, val: v, name: nm, tag: cyc});
   endtask

   task automatic expect_both(input int s, input logic [15:0] v, input string nm);
      expect_now(0, s, v, nm);
      expect_now(1, s, v, nm);
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle();
      LD = 1'b0; IDX_EN = 1'b0; IDX_INC = 1'b0; IDX_STEP = 4'd0; PC_INC = 1'b0;
   endtask

   task automatic load(input logic [3:0] a, input logic [15:0] d);
      idle(); LD = 1'b1; ADDR_A = a; DIN = d; step(); idle();
   endtask

   task automatic idx(input logic [3:0] b, input logic inc, input logic [3:0] st);
      idle(); IDX_EN = 1'b1; ADDR_B = b; IDX_INC = inc; IDX_STEP = st; step(); idle();
   endtask

   initial begin
      RESETN = 1'b0; DIN = '0; ADDR_A = '0; ADDR_B = '0; idle();
      step(); step();
      expect_both(2, 16'h0100, "reset_pc");
      expect_both(0, 16'h0000, "reset_a");
      expect_both(1, 16'h0000, "reset_b");
      expect_both(3, 16'h0000, "reset_wrap");
      step();

      RESETN = 1'b1;
      PC_INC = 1'b1; step(); step(); step(); idle();
      expect_both(2, 16'h0103, "pc_inc3");

      // Load/read; DOUT_A must still show the old value before the edge.
      LD = 1'b1; ADDR_A = 4'd3; DIN = 16'hBEEF;
      expect_both(0, 16'h0000, "load_before_edge");
      step(); idle(); ADDR_B = 4'd3;
      expect_both(0, 16'hBEEF, "load_a");
      expect_both(1, 16'hBEEF, "load_b");
      step();

      load(4'd5, 16'hFFFE);
      ADDR_A = 4'd5;
      idx(4'd5, 1'b1, 4'd3);
      expect_both(0, 16'h0001, "inc3_wrap_val");
      expect_both(3, 16'h0001, "inc3_wrap_flag");
      idx(4'd5, 1'b0, 4'd2);
      expect_both(0, 16'hFFFF, "dec2_wrap_val");
      expect_both(3, 16'h0001, "dec2_wrap_flag");
      idx(4'd5, 1'b0, 4'd1);
      expect_both(0, 16'hFFFE, "dec1_val");
      expect_both(3, 16'h0000, "dec1_no_wrap");
      idx(4'd5, 1'b1, 4'd0);
      expect_both(0, 16'hFFFE, "step0_hold");
      idx(4'd5, 1'b1, 4'd1);
      expect_both(0, 16'hFFFF, "inc1_val");
      expect_both(3, 16'h0000, "inc1_no_wrap");
      step();

      // LD wins over IDX on the same register and suppresses the would-be carry.
      load(4'd7, 16'hFFFF);
      LD = 1'b1; ADDR_A = 4'd7; DIN = 16'h1234;
      IDX_EN = 1'b1; ADDR_B = 4'd7; IDX_INC = 1'b1; IDX_STEP = 4'd1;
      step(); idle();
      expect_both(0, 16'h1234, "ld_over_idx");
      expect_both(3, 16'h0000, "ld_over_idx_wrap");
      step();

      LD = 1'b1; ADDR_A = 4'd8; DIN = 16'hAAAA;
      IDX_EN = 1'b1; ADDR_B = 4'd7; IDX_INC = 1'b1; IDX_STEP = 4'd2;
      step(); idle();
      expect_both(0, 16'hAAAA, "dual_ld");
      expect_both(1, 16'h1236, "dual_idx");
      step();

      LD = 1'b1; ADDR_A = 4'd15; DIN = 16'h0200; PC_INC = 1'b1;
      step(); idle();
      expect_both(2, 16'h0200, "pc_jump");
      step();
      IDX_EN = 1'b1; ADDR_B = 4'd15; IDX_INC = 1'b0; IDX_STEP = 4'd1; PC_INC = 1'b1;
      step(); idle();
      expect_both(2, 16'h01FF, "idx_over_pc_inc");
      expect_both(3, 16'h0000, "idx_pc_no_wrap");
      step();

      load(4'd15, 16'hFFFF);
      PC_INC = 1'b1; step(); idle();
      expect_both(2, 16'h0000, "pc_wrap_val");
      expect_both(3, 16'h0000, "pc_wrap_silent");
      step();

      // Register 0: writable in dut0, hard zero in dut1.
      load(4'd0, 16'hFFFF);
      ADDR_A = 4'd0;
      expect_now(0, 0, 16'hFFFF, "r0_load");
      expect_now(1, 0, 16'h0000, "zr0_load");
      step();
      idx(4'd0, 1'b1, 4'd1);
      expect_now(0, 0, 16'h0000, "r0_inc_val");
      expect_now(0, 3, 16'h0001, "r0_inc_wrap");
      expect_now(1, 0, 16'h0000, "zr0_inc_val");
      expect_now(1, 3, 16'h0000, "zr0_inc_wrap");
      idx(4'd0, 1'b0, 4'd1);
      expect_now(0, 0, 16'hFFFF, "r0_dec_val");
      expect_now(0, 3, 16'h0001, "r0_dec_wrap");
      expect_now(1, 1, 16'h0000, "zr0_dec_val");
      expect_now(1, 3, 16'h0000, "zr0_dec_wrap");
      step();

      // Asynchronous reset between edges while traffic is active.
      ADDR_A = 4'd5; ADDR_B = 4'd5;
      PC_INC = 1'b1; IDX_EN = 1'b1; IDX_INC = 1'b0; IDX_STEP = 4'd4;
      step();
      RESETN = 1'b0;
      #1;
      expect_both(2, 16'h0100, "async_pc");
      expect_both(0, 16'h0000, "async_a");
      expect_both(1, 16'h0000, "async_b");
      expect_both(3, 16'h0000, "async_wrap");
      step();
      expect_both(2, 16'h0100, "reset_holds_pc");
      step();
      idle(); RESETN = 1'b1;
      step();
      expect_both(2, 16'h0100, "post_reset_pc");
      step(); step();

      if (q.size() != 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
